ahb_master_arbiter: RTL and testbench



---
 rtl/ahb_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-lite arbiter with a one-deep replay holding stage per master.
// A data-phase owner register steers HWDATA and the per-master HREADYOUT.
module ahb_master_arbiter #(
    parameter int unsigned ARB_MODE   = 0,
    parameter int unsigned ADDR_WIDTH = 32,
    localparam int unsigned DATA_W    = 32
) (
    input  logic                  HCLK,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] HADDR_m0,
    input  logic [ADDR_WIDTH-1:0] HADDR_m1,
    input  logic [2:0]            HSIZE_m0,
    input  logic [2:0]            HSIZE_m1,
    input  logic [1:0]            HTRANS_m0,
    input  logic [1:0]            HTRANS_m1,
    input  logic                  HWRITE_m0,
    input  logic                  HWRITE_m1,
    input  logic [DATA_W-1:0]     HWDATA_m0,
    input  logic [DATA_W-1:0]     HWDATA_m1,
    output logic                  HREADYOUT_m0,
    output logic                  HREADYOUT_m1,
    output logic [DATA_W-1:0]     HRDATA_m0,
    output logic [DATA_W-1:0]     HRDATA_m1,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [DATA_W-1:0]     HWDATA,
    input  logic [DATA_W-1:0]     HRDATA,
    input  logic                  HREADY,
    output logic [1:0]            GRANT
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            size;
        logic                  write;
    } xfer_t;

    xfer_t [1:0]      live_c;
    logic  [1:0][1:0] trans_c;
    xfer_t [1:0]      hold_q, hold_d;
    logic  [1:0]      hold_valid_q, hold_valid_d;
    logic             dph_valid_q, dph_valid_d;
    logic             dph_owner_q, dph_owner_d;
    logic             rr_last_q, rr_last_d;

    logic  [1:0]      hro_c, issue_c, req_c, grant_c;
    logic             winner_c;
    logic             src_valid_c, src_hold_c, src_idx_c;
    xfer_t            bus_xfer_c;
    logic  [1:0]      bus_trans_c;

    assign live_c[0]  = '{addr: HADDR_m0, size: HSIZE_m0, write: HWRITE_m0};
    assign live_c[1]  = '{addr: HADDR_m1, size: HSIZE_m1, write: HWRITE_m1};
    assign trans_c[0] = HTRANS_m0;
    assign trans_c[1] = HTRANS_m1;

    // Data-phase owner sees bus HREADY; a master with a parked transfer is stalled.
    always_comb begin
        hro_c = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (dph_valid_q && (dph_owner_q == 1'(i))) begin
                hro_c[i] = HREADY;
            end else begin
                hro_c[i] = ~hold_valid_q[i];
            end
        end
    end

    assign issue_c = {trans_c[1][1] & hro_c[1], trans_c[0][1] & hro_c[0]};
    assign req_c   = hold_valid_q | issue_c;

    always_comb begin
        grant_c  = 2'b00;
        winner_c = 1'b0;
        if (HREADY) begin
            case (req_c)
                2'b01:   winner_c = 1'b0;
                2'b10:   winner_c = 1'b1;
                2'b11:   winner_c = (ARB_MODE == 1) ? ~rr_last_q : 1'b0;
                default: winner_c = 1'b0;
            endcase
            if (|req_c) begin
                grant_c = winner_c ? 2'b10 : 2'b01;
            end
        end
    end

    // While HREADY is low the stalled data-phase owner keeps its next address on the bus.
    always_comb begin
        src_valid_c = 1'b0;
        src_hold_c  = 1'b0;
        src_idx_c   = winner_c;
        bus_xfer_c  = '0;
        bus_trans_c = TRANS_IDLE;
        if (|grant_c) begin
            src_valid_c = 1'b1;
            src_hold_c  = hold_valid_q[winner_c];
        end else if (!HREADY && dph_valid_q) begin
            src_idx_c   = dph_owner_q;
            src_valid_c = trans_c[dph_owner_q][1];
        end
        if (src_valid_c) begin
            bus_xfer_c  = src_hold_c ? hold_q[src_idx_c] : live_c[src_idx_c];
            bus_trans_c = src_hold_c ? TRANS_NONSEQ : trans_c[src_idx_c];
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        dph_valid_d  = dph_valid_q;
        dph_owner_d  = dph_owner_q;
        rr_last_d    = rr_last_q;
        for (int i = 0; i < 2; i++) begin
            if (issue_c[i] && !grant_c[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_d[i]       = live_c[i];
            end else if (grant_c[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
        if (HREADY) begin
            dph_valid_d = |grant_c;
            dph_owner_d = winner_c;
        end
        if (|grant_c) begin
            rr_last_d = winner_c;
        end
    end

    always_ff @(posedge HCLK or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 2'b00;
            hold_q       <= '0;
            dph_valid_q  <= 1'b0;
            dph_owner_q  <= 1'b0;
            rr_last_q    <= 1'b1;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
            dph_valid_q  <= dph_valid_d;
            dph_owner_q  <= dph_owner_d;
            rr_last_q    <= rr_last_d;
        end
    end

    assign HREADYOUT_m0 = hro_c[0];
    assign HREADYOUT_m1 = hro_c[1];
    assign HRDATA_m0    = HRDATA;
    assign HRDATA_m1    = HRDATA;
    assign HADDR        = bus_xfer_c.addr;
    assign HSIZE        = bus_xfer_c.size;
    assign HWRITE       = bus_xfer_c.write;
    assign HTRANS       = bus_trans_c;
    assign HWDATA       = dph_owner_q ? HWDATA_m1 : HWDATA_m0;
    assign GRANT        = grant_c;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Self-checking bench for ahb_master_arbiter: fixed-priority (u0) and round-robin (u1)
// instances share master stimulus; a scoreboard queue holds expected bus address phases.
module tb_ahb_master_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;

    typedef struct {
        logic [1:0]  grant;
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic        hwrite;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] haddr_m0 = '0, haddr_m1 = '0;
    logic [2:0]  hsize_m0 = 3'd2, hsize_m1 = 3'd2;
    logic [1:0]  htrans_m0 = IDLE, htrans_m1 = IDLE;
    logic        hwrite_m0 = 1'b0, hwrite_m1 = 1'b0;
    logic [31:0] hwdata_m0 = '0, hwdata_m1 = '0;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;

    logic        hro0_m0, hro0_m1, hwrite0;
    logic [31:0] hrd0_m0, hrd0_m1, haddr0, hwdata0;
    logic [2:0]  hsize0;
    logic [1:0]  htrans0, g0;
    logic        hro1_m0, hro1_m1, hwrite1;
    logic [31:0] hrd1_m0, hrd1_m1, haddr1, hwdata1;
    logic [2:0]  hsize1;
    logic [1:0]  htrans1, g1;

    always #5 clk = ~clk;

    ahb_master_arbiter #(.ARB_MODE(0), .ADDR_WIDTH(32)) u0 (
        .HCLK(clk), .reset(rst),
        .HADDR_m0(haddr_m0), .HADDR_m1(haddr_m1), .HSIZE_m0(hsize_m0), .HSIZE_m1(hsize_m1),
        .HTRANS_m0(htrans_m0), .HTRANS_m1(htrans_m1), .HWRITE_m0(hwrite_m0), .HWRITE_m1(hwrite_m1),
        .HWDATA_m0(hwdata_m0), .HWDATA_m1(hwdata_m1),
        .HREADYOUT_m0(hro0_m0), .HREADYOUT_m1(hro0_m1), .HRDATA_m0(hrd0_m0), .HRDATA_m1(hrd0_m1),
        .HADDR(haddr0), .HSIZE(hsize0), .HTRANS(htrans0), .HWRITE(hwrite0), .HWDATA(hwdata0),
        .HRDATA(hrdata), .HREADY(hready), .GRANT(g0)
    );

    ahb_master_arbiter #(.ARB_MODE(1), .ADDR_WIDTH(32)) u1 (
        .HCLK(clk), .reset(rst),
        .HADDR_m0(haddr_m0), .HADDR_m1(haddr_m1), .HSIZE_m0(hsize_m0), .HSIZE_m1(hsize_m1),
        .HTRANS_m0(htrans_m0), .HTRANS_m1(htrans_m1), .HWRITE_m0(hwrite_m0), .HWRITE_m1(hwrite_m1),
        .HWDATA_m0(hwdata_m0), .HWDATA_m1(hwdata_m1),
        .HREADYOUT_m0(hro1_m0), .HREADYOUT_m1(hro1_m1), .HRDATA_m0(hrd1_m0), .HRDATA_m1(hrd1_m1),
        .HADDR(haddr1), .HSIZE(hsize1), .HTRANS(htrans1), .HWRITE(hwrite1), .HWDATA(hwdata1),
        .HRDATA(hrdata), .HREADY(hready), .GRANT(g1)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_masters();
        htrans_m0 = IDLE;
        htrans_m1 = IDLE;
        haddr_m0  = '0;
        haddr_m1  = '0;
        hwrite_m0 = 1'b0;
        hwrite_m1 = 1'b0;
        hready    = 1'b1;
    endtask

    task automatic do_reset();
        idle_masters();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_masters();
        rst = 1'b1;
        #2;
        checks++;
        if ({g0, htrans0} !== {2'b00, IDLE}) begin
            errors++;
            $display("FAIL reset_u0_bus: grant/htrans=%b/%b want 00/00", g0, htrans0);
        end
        checks++;
        if ({hro0_m0, hro0_m1} !== 2'b11) begin
            errors++;
            $display("FAIL reset_u0_hreadyout: %b want 11", {hro0_m0, hro0_m1});
        end
        checks++;
        if ({g1, htrans1, hro1_m0, hro1_m1} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_u1: grant/htrans/hro=%b/%b/%b%b want 00/00/11", g1, htrans1, hro1_m0, hro1_m1);
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single_master();
        do_reset();
        htrans_m0 = NONSEQ; haddr_m0 = 32'h0000_0100; hwrite_m0 = 1'b0;
        sb.push_back('{2'b01, NONSEQ, 32'h0000_0100, 1'b0});
        #2;
        e = sb.pop_front();
        checks++;
        if ({g0, htrans0, haddr0, hwrite0} !== {e.grant, e.htrans, e.haddr, e.hwrite}) begin
            errors++;
            $display("FAIL single_addr: got %b %b %h %b want %b %b %h %b", g0, htrans0, haddr0, hwrite0, e.grant, e.htrans, e.haddr, e.hwrite);
        end
        next_cycle();
        idle_masters();
        hrdata = 32'hCAFE_0001;
        sb.push_back('{2'b00, IDLE, 32'h0, 1'b0});
        #2;
        checks++;
        if ({hro0_m0, hrd0_m0, hrd0_m1} !== {1'b1, 32'hCAFE_0001, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL single_data: hro=%b hrdata_m0=%h hrdata_m1=%h want 1 cafe0001 cafe0001", hro0_m0, hrd0_m0, hrd0_m1);
        end
        e = sb.pop_front();
        checks++;
        if ({g0, htrans0} !== {e.grant, e.htrans}) begin
            errors++;
            $display("FAIL single_idle: got %b %b want %b %b", g0, htrans0, e.grant, e.htrans);
        end
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        htrans_m0 = NONSEQ; haddr_m0 = 32'h2000_0000; hwrite_m0 = 1'b0; hwdata_m0 = 32'h1111_1111;
        htrans_m1 = NONSEQ; haddr_m1 = 32'h2000_0004; hwrite_m1 = 1'b1; hwdata_m1 = 32'h0;
        sb.push_back('{2'b01, NONSEQ, 32'h2000_0000, 1'b0});
        #2;
        e = sb.pop_front();
        checks++;
        if ({g0, htrans0, haddr0, hwrite0} !== {e.grant, e.htrans, e.haddr, e.hwrite}) begin
            errors++;
            $display("FAIL fixed_first: got %b %b %h %b want %b %b %h %b", g0, htrans0, haddr0, hwrite0, e.grant, e.htrans, e.haddr, e.hwrite);
        end
        next_cycle();
        htrans_m0 = IDLE;
        sb.push_back('{2'b10, NONSEQ, 32'h2000_0004, 1'b1});
        #2;
        checks++;
        if (hro0_m1 !== 1'b0) begin
            errors++;
            $display("FAIL fixed_stall_m1: hreadyout_m1=%b want 0", hro0_m1);
        end
        e = sb.pop_front();
        checks++;
        if ({g0, htrans0, haddr0, hwrite0} !== {e.grant, e.htrans, e.haddr, e.hwrite}) begin
            errors++;
            $display("FAIL fixed_replay: got %b %b %h %b want %b %b %h %b", g0, htrans0, haddr0, hwrite0, e.grant, e.htrans, e.haddr, e.hwrite);
        end
        next_cycle();
        htrans_m1 = IDLE; hwdata_m1 = 32'hDEAD_BEEF;
        #2;
        checks++;
        if ({hwdata0, hro0_m1, g0} !== {32'hDEAD_BEEF, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL fixed_wdata: hwdata=%h hro_m1=%b grant=%b want deadbeef 1 00", hwdata0, hro0_m1, g0);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        do_reset();
        htrans_m0 = NONSEQ; haddr_m0 = 32'h0000_1000;
        htrans_m1 = NONSEQ; haddr_m1 = 32'h0000_2000;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) sb.push_back('{2'b01, NONSEQ, 32'h0000_1000, 1'b0});
            else            sb.push_back('{2'b10, NONSEQ, 32'h0000_2000, 1'b0});
            #2;
            e = sb.pop_front();
            checks++;
            if ({g1, htrans1, haddr1} !== {e.grant, e.htrans, e.haddr}) begin
                errors++;
                $display("FAIL rr_cycle%0d: got %b %b %h want %b %b %h", k, g1, htrans1, haddr1, e.grant, e.htrans, e.haddr);
            end
            next_cycle();
        end
        idle_masters();
    endtask

    task automatic test_hready_stall();
        do_reset();
        htrans_m0 = NONSEQ; haddr_m0 = 32'h0000_0300;
        sb.push_back('{2'b01, NONSEQ, 32'h0000_0300, 1'b0});
        #2;
        e = sb.pop_front();
        checks++;
        if ({g0, htrans0, haddr0} !== {e.grant, e.htrans, e.haddr}) begin
            errors++;
            $display("FAIL stall_first: got %b %b %h want %b %b %h", g0, htrans0, haddr0, e.grant, e.htrans, e.haddr);
        end
        next_cycle();
        htrans_m0 = IDLE;
        htrans_m1 = NONSEQ; haddr_m1 = 32'h0000_0400; hwrite_m1 = 1'b1;
        hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if ({g0, hro0_m0, hro0_m1} !== {2'b00, 1'b0, (k == 0)}) begin
                errors++;
                $display("FAIL stall_wait%0d: grant=%b hro_m0=%b hro_m1=%b want 00 0 %b", k, g0, hro0_m0, hro0_m1, (k == 0));
            end
            next_cycle();
        end
        hready = 1'b1;
        sb.push_back('{2'b10, NONSEQ, 32'h0000_0400, 1'b1});
        #2;
        e = sb.pop_front();
        checks++;
        if ({g0, htrans0, haddr0, hwrite0} !== {e.grant, e.htrans, e.haddr, e.hwrite}) begin
            errors++;
            $display("FAIL stall_release: got %b %b %h %b want %b %b %h %b", g0, htrans0, haddr0, hwrite0, e.grant, e.htrans, e.haddr, e.hwrite);
        end
        next_cycle();
        idle_masters();
        #2;
        checks++;
        if ({hro0_m1, g0} !== {1'b1, 2'b00}) begin
            errors++;
            $display("FAIL stall_after: hro_m1=%b grant=%b want 1 00", hro0_m1, g0);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        htrans_m0 = NONSEQ; haddr_m0 = 32'h0000_0500;
        htrans_m1 = NONSEQ; haddr_m1 = 32'h0000_0600; hwrite_m1 = 1'b1;
        next_cycle();
        idle_masters();
        #1;
        checks++;
        if (hro0_m1 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_held: hro_m1=%b want 0", hro0_m1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({htrans0, g0, hro0_m0, hro0_m1} !== {IDLE, 2'b00, 2'b11}) begin
            errors++;
            $display("FAIL midrst_clear: htrans=%b grant=%b hro=%b%b want 00 00 11", htrans0, g0, hro0_m0, hro0_m1);
        end
        next_cycle();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{2'b00, IDLE, 32'h0, 1'b0});
            #2;
            e = sb.pop_front();
            checks++;
            if ({g0, htrans0} !== {e.grant, e.htrans}) begin
                errors++;
                $display("FAIL midrst_noreplay%0d: got %b %b want %b %b", k, g0, htrans0, e.grant, e.htrans);
            end
            next_cycle();
        end
    endtask

    task automatic test_idle_busy();
        logic [1:0] kinds [2];
        kinds[0] = IDLE;
        kinds[1] = BUSY;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            htrans_m1 = kinds[k]; haddr_m1 = 32'h0000_0700; hwrite_m1 = 1'b1;
            sb.push_back('{2'b00, IDLE, 32'h0, 1'b0});
            #2;
            e = sb.pop_front();
            checks++;
            if ({g0, htrans0} !== {e.grant, e.htrans}) begin
                errors++;
                $display("FAIL idle_fwd%0d: got %b %b want %b %b", k, g0, htrans0, e.grant, e.htrans);
            end
            next_cycle();
            #2;
            checks++;
            if ({hro0_m1, g0} !== {1'b1, 2'b00}) begin
                errors++;
                $display("FAIL idle_capture%0d: hro_m1=%b grant=%b want 1 00", k, hro0_m1, g0);
            end
            next_cycle();
        end
        idle_masters();
    endtask

    initial begin
        next_cycle();
        test_reset();
        test_single_master();
        test_fixed_priority();
        test_round_robin();
        test_hready_stall();
        test_reset_mid_hold();
        test_idle_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
